// File: rtl/dff_bank_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dff_bank_write_arbiter_pkg
//
// Shared encodings for the register-bank write arbiter:
//   owner_t : who owns the Tick/WrData driven in the current cycle
//   state_t : arbiter FSM states
//   owner_of: maps an FSM state onto the Owner value it presents
// -----------------------------------------------------------------------------
package dff_bank_write_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_A    = 2'd1,
        OWNER_B    = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        LOCK_B  = 2'd3
    } state_t;

    // LOCK_B reports B as owner even when no write is in flight, so the
    // debug host can see it still holds the port.
    function automatic owner_t owner_of(input state_t s);
        owner_t o;
        case (s)
            GRANT_A:        o = OWNER_A;
            GRANT_B,
            LOCK_B:         o = OWNER_B;
            default:        o = OWNER_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/dff_bank_write_arbiter_reg_tick_decoder.sv
// -----------------------------------------------------------------------------
// reg_tick_decoder
//
// Combinational register-address decoder for the flip-flop bank.
//   addr     in  ADDR_W    register index to decode
//   onehot   out NUM_REGS  one-hot enable; all zeros when addr is out of range
//   out_of_range out 1     addr >= NUM_REGS
// The parent registers both outputs.
// -----------------------------------------------------------------------------
module reg_tick_decoder #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_REGS-1:0] onehot,
    output logic                out_of_range
);

    // One extra bit so NUM_REGS == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

    // Each bit is an independent equality compare, so an address beyond the
    // bank simply matches nothing and the vector stays zero.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
        assign onehot[gi] = (addr == ADDR_W'(gi));
    end

    assign out_of_range = ({1'b0, addr} >= NUM_REGS_EXT);

endmodule

// File: rtl/dff_bank_write_arbiter.sv
// -----------------------------------------------------------------------------
// dff_bank_write_arbiter
//
// Arbitrates the single write port of a D-flip-flop register bank between
// requester A (CPU writeback) and requester B (debug/host). Round-robin with a
// debug lock mode; every output is registered, so a request sampled at edge k
// drives Tick/WrData/Ack/Owner during cycle k+1 and the bank captures at k+1.
//
// Ports:
//   Clock            single system clock, rising edge
//   Reset            synchronous active-high reset
//   Halt             blocks new grants
//   A_Req/Addr/Data  requester A write request (held until A_Ack)
//   A_Ack            one-cycle pulse: A's write is performed this cycle
//   B_Req/Addr/Data  requester B write request (held until B_Ack)
//   B_Lock           B asks for exclusive ownership of the port
//   B_Ack            one-cycle pulse: B's write is performed this cycle
//   Tick             one-hot register enable (zero when idle / out of range)
//   WrData           data to every register D input; holds when idle
//   Owner            0 none, 1 A, 2 B
//   Locked           high while the port is locked to B
//   AddrErr          pulses with the Ack when the granted address >= NUM_REGS
// -----------------------------------------------------------------------------
module dff_bank_write_arbiter
    import dff_bank_write_arbiter_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Halt,
    input  logic                A_Req,
    input  logic [ADDR_W-1:0]   A_Addr,
    input  logic [DATA_W-1:0]   A_Data,
    output logic                A_Ack,
    input  logic                B_Req,
    input  logic                B_Lock,
    input  logic [ADDR_W-1:0]   B_Addr,
    input  logic [DATA_W-1:0]   B_Data,
    output logic                B_Ack,
    output logic [NUM_REGS-1:0] Tick,
    output logic [DATA_W-1:0]   WrData,
    output logic [1:0]          Owner,
    output logic                Locked,
    output logic                AddrErr
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_reg,    state_next;
    logic                last_b_reg,   last_b_next;   // 1: B granted most recently
    logic                a_ack_reg,    a_ack_next;
    logic                b_ack_reg,    b_ack_next;
    logic [NUM_REGS-1:0] tick_reg,     tick_next;
    logic [DATA_W-1:0]   wr_data_reg,  wr_data_next;
    logic [1:0]          owner_reg,    owner_next;
    logic                locked_reg,   locked_next;
    logic                addr_err_reg, addr_err_next;

    // ------------------------------------------------------------------
    // Arbitration signals
    // ------------------------------------------------------------------
    logic                lock_hold;
    logic                a_elig;
    logic                b_elig;
    logic                grant_a;
    logic                grant_b;
    logic                grant_any;
    logic [ADDR_W-1:0]   grant_addr;
    logic [NUM_REGS-1:0] dec_onehot;
    logic                dec_oor;

    // A requester whose Ack is high this cycle is still showing Req from the
    // write being performed now; it must not be granted again at this edge.
    assign lock_hold = (state_reg == LOCK_B) && B_Lock;
    assign a_elig    = A_Req && !a_ack_reg && !lock_hold && !Halt;
    assign b_elig    = B_Req && !b_ack_reg && !Halt;

    // On contention the requester not granted most recently wins. While the
    // lock holds, A is never eligible, so B wins whenever it asks.
    assign grant_a   = a_elig && (!b_elig || last_b_reg);
    assign grant_b   = b_elig && !grant_a;
    assign grant_any = grant_a || grant_b;

    assign grant_addr = grant_a ? A_Addr : B_Addr;

    reg_tick_decoder #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_tick_dec (
        .addr         (grant_addr),
        .onehot       (dec_onehot),
        .out_of_range (dec_oor)
    );

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = IDLE;
        last_b_next   = last_b_reg;
        a_ack_next    = grant_a;
        b_ack_next    = grant_b;
        tick_next     = '0;
        wr_data_next  = wr_data_reg;
        addr_err_next = 1'b0;

        // Lock is entered only by actually granting B with B_Lock high, and
        // persists (even through idle or halted cycles) until B_Lock is
        // sampled low.
        if (grant_b && B_Lock) begin
            state_next = LOCK_B;
        end else if (lock_hold) begin
            state_next = LOCK_B;
        end else if (grant_a) begin
            state_next = GRANT_A;
        end else if (grant_b) begin
            state_next = GRANT_B;
        end else begin
            state_next = IDLE;
        end

        // Pointer moves only when somebody is actually granted.
        if (grant_a) begin
            last_b_next = 1'b0;
        end else if (grant_b) begin
            last_b_next = 1'b1;
        end

        if (grant_any) begin
            tick_next     = dec_onehot;
            wr_data_next  = grant_a ? A_Data : B_Data;
            addr_err_next = dec_oor;
        end

        owner_next  = owner_of(state_next);
        locked_next = (state_next == LOCK_B);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Reset has priority over any grant decided at the same edge, so such a
    // write is dropped and the pointer returns to favouring A.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg    <= IDLE;
            last_b_reg   <= 1'b1;
            a_ack_reg    <= 1'b0;
            b_ack_reg    <= 1'b0;
            tick_reg     <= '0;
            wr_data_reg  <= '0;
            owner_reg    <= OWNER_NONE;
            locked_reg   <= 1'b0;
            addr_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            last_b_reg   <= last_b_next;
            a_ack_reg    <= a_ack_next;
            b_ack_reg    <= b_ack_next;
            tick_reg     <= tick_next;
            wr_data_reg  <= wr_data_next;
            owner_reg    <= owner_next;
            locked_reg   <= locked_next;
            addr_err_reg <= addr_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign A_Ack   = a_ack_reg;
    assign B_Ack   = b_ack_reg;
    assign Tick    = tick_reg;
    assign WrData  = wr_data_reg;
    assign Owner   = owner_reg;
    assign Locked  = locked_reg;
    assign AddrErr = addr_err_reg;

endmodule

// File: tb/tb_dff_bank_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dff_bank_write_arbiter
//
// Drives a 32-register and a 24-register arbiter from the same stimulus and
// compares both against a behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_dff_bank_write_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus
    logic        reset;
    logic        halt;
    logic        a_req;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_req;
    logic        b_lock;
    logic [4:0]  b_addr;
    logic [31:0] b_data;

    // 32-register instance outputs
    logic        a_ack32, b_ack32, locked32, err32;
    logic [31:0] tick32, wr32;
    logic [1:0]  owner32;

    // 24-register instance outputs
    logic        a_ack24, b_ack24, locked24, err24;
    logic [23:0] tick24;
    logic [31:0] wr24;
    logic [1:0]  owner24;

    dff_bank_write_arbiter #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) u_dut32 (
        .Clock   (clk),
        .Reset   (reset),
        .Halt    (halt),
        .A_Req   (a_req),
        .A_Addr  (a_addr),
        .A_Data  (a_data),
        .A_Ack   (a_ack32),
        .B_Req   (b_req),
        .B_Lock  (b_lock),
        .B_Addr  (b_addr),
        .B_Data  (b_data),
        .B_Ack   (b_ack32),
        .Tick    (tick32),
        .WrData  (wr32),
        .Owner   (owner32),
        .Locked  (locked32),
        .AddrErr (err32)
    );

    dff_bank_write_arbiter #(.NUM_REGS(24), .ADDR_W(5), .DATA_W(32)) u_dut24 (
        .Clock   (clk),
        .Reset   (reset),
        .Halt    (halt),
        .A_Req   (a_req),
        .A_Addr  (a_addr),
        .A_Data  (a_data),
        .A_Ack   (a_ack24),
        .B_Req   (b_req),
        .B_Lock  (b_lock),
        .B_Addr  (b_addr),
        .B_Data  (b_data),
        .B_Ack   (b_ack24),
        .Tick    (tick24),
        .WrData  (wr24),
        .Owner   (owner24),
        .Locked  (locked24),
        .AddrErr (err24)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_xact   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: who is allowed to write, who wins, what is shown.
    // ------------------------------------------------------------------
    bit          m_prefer_a;   // A wins a tie when B was served last
    bit          m_locked;
    bit          m_a_ack, m_b_ack;
    logic [31:0] m_wr;
    logic [1:0]  m_owner;
    logic [31:0] m_tick32;
    logic [31:0] m_tick24;
    bit          m_err32, m_err24;

    // Predictions for the coming edge
    bit          p_prefer_a, p_locked, p_a_ack, p_b_ack, p_err32, p_err24;
    logic [31:0] p_wr, p_tick32, p_tick24;
    logic [1:0]  p_owner;

    function automatic logic [31:0] enable_for(input int addr, input int nregs);
        return (addr < nregs) ? (32'd1 << addr) : 32'd0;
    endfunction

    task automatic predict();
        int  winner;       // 0 none, 1 A, 2 B
        bit  a_can, b_can, lock_stays;
        int  addr;
        if (reset) begin
            p_prefer_a = 1; p_locked = 0; p_a_ack = 0; p_b_ack = 0;
            p_wr = '0; p_owner = 2'd0; p_tick32 = '0; p_tick24 = '0;
            p_err32 = 0; p_err24 = 0;
            return;
        end
        lock_stays = m_locked && b_lock;
        a_can = a_req && !m_a_ack && !lock_stays && !halt;
        b_can = b_req && !m_b_ack && !halt;
        if (a_can && b_can)  winner = m_prefer_a ? 1 : 2;
        else if (a_can)      winner = 1;
        else if (b_can)      winner = 2;
        else                 winner = 0;

        p_locked   = (winner == 2 && b_lock) || lock_stays;
        p_prefer_a = (winner == 0) ? m_prefer_a : (winner == 2);
        p_a_ack    = (winner == 1);
        p_b_ack    = (winner == 2);
        p_owner    = (winner != 0) ? 2'(winner) : (p_locked ? 2'd2 : 2'd0);
        p_wr       = (winner == 1) ? a_data : (winner == 2) ? b_data : m_wr;
        addr       = (winner == 1) ? int'(a_addr) : int'(b_addr);
        p_tick32   = (winner != 0) ? enable_for(addr, 32) : 32'd0;
        p_tick24   = (winner != 0) ? enable_for(addr, 24) : 32'd0;
        p_err32    = (winner != 0) && (addr >= 32);
        p_err24    = (winner != 0) && (addr >= 24);
    endtask

    task automatic step();
        predict();
        @(posedge clk);
        #1;
        m_prefer_a = p_prefer_a; m_locked = p_locked;
        m_a_ack = p_a_ack; m_b_ack = p_b_ack; m_wr = p_wr; m_owner = p_owner;
        m_tick32 = p_tick32; m_tick24 = p_tick24; m_err32 = p_err32; m_err24 = p_err24;

        chk("a_ack32",  64'(a_ack32),  64'(m_a_ack));
        chk("b_ack32",  64'(b_ack32),  64'(m_b_ack));
        chk("tick32",   64'(tick32),   64'(m_tick32));
        chk("wrdata32", 64'(wr32),     64'(m_wr));
        chk("owner32",  64'(owner32),  64'(m_owner));
        chk("locked32", 64'(locked32), 64'(m_locked));
        chk("err32",    64'(err32),    64'(m_err32));
        chk("a_ack24",  64'(a_ack24),  64'(m_a_ack));
        chk("b_ack24",  64'(b_ack24),  64'(m_b_ack));
        chk("tick24",   64'(tick24),   64'(m_tick24));
        chk("wrdata24", 64'(wr24),     64'(m_wr));
        chk("owner24",  64'(owner24),  64'(m_owner));
        chk("locked24", 64'(locked24), 64'(m_locked));
        chk("err24",    64'(err24),    64'(m_err24));

        if (m_a_ack || m_b_ack) begin
            n_xact++;
            $display("xact %0d t=%0t owner=%0d tick32=%h tick24=%h data=%h err24=%0d locked=%0d",
                     n_xact, $time, owner32, tick32, tick24, wr32, err24, locked32);
        end
    endtask

    task automatic drive(input bit rst, input bit h,
                         input bit ar, input logic [4:0] aa, input logic [31:0] ad,
                         input bit br, input bit bl, input logic [4:0] ba, input logic [31:0] bd,
                         input int cycles);
        reset = rst; halt = h;
        a_req = ar; a_addr = aa; a_data = ad;
        b_req = br; b_lock = bl; b_addr = ba; b_data = bd;
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        reset = 1; halt = 0; a_req = 0; a_addr = 0; a_data = 0;
        b_req = 0; b_lock = 0; b_addr = 0; b_data = 0;
        m_prefer_a = 1; m_locked = 0; m_a_ack = 0; m_b_ack = 0;
        m_wr = '0; m_owner = '0; m_tick32 = '0; m_tick24 = '0; m_err32 = 0; m_err24 = 0;

        // Reset, then single A write with masking on the following edge
        drive(1, 0, 0, 0, 0,            0, 0, 0, 0,            2);
        drive(0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0,            3);
        drive(0, 0, 0, 3, 32'hDEADBEEF, 0, 0, 0, 0,            1);

        // Both requesting continuously: 1 write per cycle, A first
        drive(1, 0, 0, 0, 0,            0, 0, 0, 0,            1);
        drive(0, 0, 1, 1, 32'h1111_1111, 1, 0, 2, 32'h2222_2222, 8);

        // Lock: B takes the port, A is shut out until B_Lock drops
        drive(1, 0, 0, 0, 0,            0, 0, 0, 0,            1);
        drive(0, 0, 0, 1, 32'hAAAA_0001, 1, 1, 4, 32'hBBBB_0001, 1);
        drive(0, 0, 1, 1, 32'hAAAA_0001, 1, 1, 4, 32'hBBBB_0001, 6);
        drive(0, 0, 1, 1, 32'hAAAA_0001, 1, 0, 4, 32'hBBBB_0001, 3);

        // Halt for 3 cycles with both requesting
        drive(0, 0, 1, 5, 32'h5555_0000, 1, 0, 6, 32'h6666_0000, 2);
        drive(0, 1, 1, 5, 32'h5555_0000, 1, 0, 6, 32'h6666_0000, 3);
        drive(0, 0, 1, 5, 32'h5555_0000, 1, 0, 6, 32'h6666_0000, 3);

        // Top register, then Halt while that write is in flight
        drive(1, 0, 0, 0, 0,            0, 0, 0, 0,            1);
        drive(0, 0, 1, 31, 32'h3131_3131, 0, 0, 0, 0,          1);
        drive(0, 1, 1, 31, 32'h3131_3131, 0, 0, 0, 0,          2);
        // Address in range for 32 regs but beyond the 24-register bank
        drive(0, 0, 1, 30, 32'h3030_3030, 0, 0, 0, 0,          1);
        drive(0, 0, 0, 30, 32'h3030_3030, 0, 0, 0, 0,          1);

        // Reset at the edge a grant would be made, then A favoured again
        drive(0, 0, 0, 0, 0,            1, 0, 7, 32'h7777_7777, 1);
        drive(0, 0, 0, 0, 0,            0, 0, 7, 32'h7777_7777, 1);
        drive(1, 0, 1, 9, 32'h9999_9999, 0, 0, 7, 32'h7777_7777, 1);
        drive(0, 0, 1, 9, 32'h9999_9999, 1, 0, 7, 32'h7777_7777, 3);

        // Randomized traffic respecting hold-until-Ack (with occasional drops)
        reset = 0; halt = 0; a_req = 0; b_req = 0; b_lock = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset = ($urandom_range(0, 63) == 0);
            halt  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) b_lock = ~b_lock;
            if (!a_req || m_a_ack || $urandom_range(0, 15) == 0) begin
                a_req  = ($urandom_range(0, 2) != 0);
                a_addr = 5'($urandom);
                a_data = $urandom;
            end
            if (!b_req || m_b_ack || $urandom_range(0, 15) == 0) begin
                b_req  = ($urandom_range(0, 2) != 0);
                b_addr = 5'($urandom);
                b_data = $urandom;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dff_bank_write_arbiter.md
Name: dff_bank_write_arbiter

Overview:
- Arbitrates the single write port of a D-flip-flop register bank between two requesters:
  - Requester A: CPU writeback.
  - Requester B: debug/host port.
- Produces the per-register one-hot Tick (clock-enable) vector and the shared write data that drive the flip-flop bank's D/Tick inputs.
- Arbitration is round-robin with a debug lock mode; all outputs are registered. Sits between the CPU core and the register bank in the single-cycle CPU.

Parameters:
- NUM_REGS, 32, number of registers in the bank (width of Tick).
- ADDR_W, 5, register address width; must satisfy 2^ADDR_W >= NUM_REGS.
- DATA_W, 32, register data width.

Ports:
- Clock  in  1  single system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Halt  in  1  when high, no new grants are made.
- A_Req  in  1  requester A write request; held until A_Ack.
- A_Addr  in  ADDR_W  requester A target register.
- A_Data  in  DATA_W  requester A write data.
- A_Ack  out  1  one-cycle pulse: A's write is being performed this cycle.
- B_Req  in  1  requester B write request; held until B_Ack.
- B_Lock  in  1  B requests exclusive ownership of the port.
- B_Addr  in  ADDR_W  requester B target register.
- B_Data  in  DATA_W  requester B write data.
- B_Ack  out  1  one-cycle pulse: B's write is being performed this cycle.
- Tick  out  NUM_REGS  one-hot register enable; at most one bit high.
- WrData  out  DATA_W  data presented to the D inputs of every register.
- Owner  out  2  0 = none, 1 = A, 2 = B (owner of the current Tick).
- Locked  out  1  high while in LOCK_B.
- AddrErr  out  1  one-cycle pulse: granted address was >= NUM_REGS.

Behaviour:
- Reset (synchronous, sampled at edge):
  - Tick, WrData, A_Ack, B_Ack, Owner, Locked, AddrErr all 0; state IDLE; round-robin pointer favours A.
  - A write granted at the reset edge is dropped: Tick stays 0 the following cycle.
- Latency:
  - Request sampled at edge k, grant decided at edge k.
  - Tick/WrData/Ack/Owner are valid during cycle k+1.
  - The register bank captures at edge k+1.
- Grant masking:
  - A requester granted at edge k is ineligible at edge k+1, because its Req is still high while it sees Ack.
  - Per-requester throughput is therefore at most 1 write per 2 cycles.
  - With both requesters active and alternating, the port reaches 1 write per cycle.
- Round-robin:
  - When both are eligible, the one not granted most recently wins.
  - The pointer updates only on a grant.
- States and transitions:
  - IDLE: no grant this cycle.
  - GRANT_A: Tick/Ack owned by A.
  - GRANT_B: Tick/Ack owned by B.
  - LOCK_B: B granted and B_Lock sampled high. A is fully blocked; B is granted whenever eligible; Owner=2 and Locked=1 persist even in idle cycles.
  - Exit LOCK_B when B_Lock is sampled low at an edge. A becomes eligible at that same edge and wins if requesting, since B was most recent.
- Halt:
  - High at edge k: no grant at k, so outputs are idle in cycle k+1.
  - A write already granted at edge k-1 still completes in cycle k.
  - LOCK_B is retained across Halt.
- Address out of range (Addr >= NUM_REGS):
  - Grant and Ack proceed normally.
  - Tick is all zeros and AddrErr pulses with the Ack.
- Tick is one-hot or zero, never multi-hot. WrData holds its last value when idle.
- A request dropped before Ack is simply not granted; this is legal.

Decomposition:
- Shared package holds:
  - Owner encodings OWNER_NONE=0, OWNER_A=1, OWNER_B=2.
  - State encodings IDLE, GRANT_A, GRANT_B, LOCK_B.
- One natural sub-module: reg_tick_decoder, a combinational ADDR_W to NUM_REGS one-hot decoder with an out-of-range flag. Its output is registered in the parent.

Test Plan:
- Reset then A_Req=1, A_Addr=3, A_Data=0xDEADBEEF at edge 1 -> cycle 2: Tick=0x00000008, WrData=0xDEADBEEF, A_Ack=1, Owner=1; with A_Req held, cycle 3 is idle (masking).
- A and B both requesting continuously, addrs 1/2 -> Tick alternates 0x2, 0x4, 0x2, 0x4, A first; exactly one Ack per cycle; no cycle is idle.
- B_Req=1, B_Lock=1 with A_Req=1 for 6 cycles -> only B_Ack pulses, every other cycle, Locked=1; drop B_Lock -> A_Ack within 2 cycles.
- Halt=1 for 3 cycles with both requesting -> Tick=0 and no Acks for those cycles except a write granted before Halt, which completes; grants resume the cycle after Halt falls.
- NUM_REGS=32 instance with A_Addr=31, then Halt during the in-flight grant -> Tick bit 31 set. A separate instance with NUM_REGS=24 and A_Addr=30 -> A_Ack=1, Tick=0, AddrErr=1.
- Reset asserted at the edge a grant is made -> following cycle Tick=0, Acks=0, state IDLE, A favoured next.
